video_timing_ctrl: RTL and testbench

VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

---
 rtl/video_timing_ctrl_pkg.sv | 36 +++
 rtl/video_timing_ctrl_sync_delay.sv | 31 +++
 rtl/video_timing_ctrl.sv | 120 ++++++++++++
 tb/tb_video_timing_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/video_timing_ctrl_pkg.sv
// 720p timing constants and shared counter/sync types for the video timing generator.
// Used by video_timing_ctrl (optional VIDEO_FRAME_COUNT_EN feature lives in the top).
package video_pkg;

   localparam int H_ACTIVE_720P = 1280;
   localparam int H_FP_720P     = 110;
   localparam int H_SYNC_720P   = 40;
   localparam int H_BP_720P     = 220;
   localparam int H_TOTAL       = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;

   localparam int V_ACTIVE_720P = 720;
   localparam int V_FP_720P     = 5;
   localparam int V_SYNC_720P   = 5;
   localparam int V_BP_720P     = 20;
   localparam int V_TOTAL       = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

   typedef logic [10:0] hcount_t;
   typedef logic [9:0]  vcount_t;
   typedef logic [5:0]  frame_t;

   // Field order fixes the bit layout carried through the delay line.
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } sync_bus_t;

   function automatic logic in_window_h(input hcount_t cnt, input hcount_t lo, input hcount_t hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

   function automatic logic in_window_v(input vcount_t cnt, input vcount_t lo, input vcount_t hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

endpackage

// File: rtl/video_timing_ctrl_sync_delay.sv
// Fixed-latency shift register keeping a bundle of control bits mutually aligned.
// Every stage clears on the asynchronous active-high reset.
module sync_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [DEPTH];

   // Shift the bundle one stage per clock; reset empties the whole line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/video_timing_ctrl.sv
// Free-running raster timing generator: undelayed counters, syncs delayed to match the pixel pipe.
// Define VIDEO_FRAME_COUNT_EN to add the frame_count_out port and its counter.
module video_timing_ctrl
   import video_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_720P,
   parameter int H_FP       = H_FP_720P,
   parameter int H_SYNC     = H_SYNC_720P,
   parameter int H_BP       = H_BP_720P,
   parameter int V_ACTIVE   = V_ACTIVE_720P,
   parameter int V_FP       = V_FP_720P,
   parameter int V_SYNC     = V_SYNC_720P,
   parameter int V_BP       = V_BP_720P,
   parameter int PIPE_DEPTH = 4,
   parameter int FPS        = 60
) (
   input  logic        clk_in,
   input  logic        rst_in,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        active_draw_out,
   output logic        hor_sync_out,
   output logic        vert_sync_out,
   output logic        new_frame_out
`ifdef VIDEO_FRAME_COUNT_EN
   ,
   output logic [5:0]  frame_count_out
`endif
);

   localparam hcount_t H_ACT_C   = hcount_t'(H_ACTIVE);
   localparam hcount_t H_SYNC_LO = hcount_t'(H_ACTIVE + H_FP);
   localparam hcount_t H_SYNC_HI = hcount_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam hcount_t H_LAST_C  = hcount_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam vcount_t V_ACT_C   = vcount_t'(V_ACTIVE);
   localparam vcount_t V_SYNC_LO = vcount_t'(V_ACTIVE + V_FP);
   localparam vcount_t V_SYNC_HI = vcount_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam vcount_t V_LAST_C  = vcount_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   hcount_t   hcount_r;
   vcount_t   vcount_r;
   hcount_t   h_next_s;
   vcount_t   v_next_s;
   logic      new_frame_r;
   sync_bus_t raw_s;
   sync_bus_t dly_s;

   // Raster position after the next edge; vertical advances only on a line wrap.
   always_comb begin
      h_next_s = hcount_r + 11'd1;
      v_next_s = vcount_r;
      if (hcount_r == H_LAST_C) begin
         h_next_s = 11'd0;
         if (vcount_r == V_LAST_C) begin
            v_next_s = 10'd0;
         end else begin
            v_next_s = vcount_r + 10'd1;
         end
      end else begin
         v_next_s = vcount_r;
      end
   end

   // Counters and the frame pulse, which is decoded ahead so it lines up with the counters.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hcount_r    <= 11'd0;
         vcount_r    <= 10'd0;
         new_frame_r <= 1'b0;
      end else begin
         hcount_r    <= h_next_s;
         vcount_r    <= v_next_s;
         new_frame_r <= (h_next_s == H_ACT_C) && (v_next_s == V_ACT_C);
      end
   end

   assign raw_s.active = (hcount_r < H_ACT_C) && (vcount_r < V_ACT_C);
   assign raw_s.hsync  = in_window_h(hcount_r, H_SYNC_LO, H_SYNC_HI);
   assign raw_s.vsync  = in_window_v(vcount_r, V_SYNC_LO, V_SYNC_HI);

   sync_delay #(
      .WIDTH (3),
      .DEPTH (PIPE_DEPTH)
   ) u_sync_delay (
      .clk (clk_in),
      .rst (rst_in),
      .d   (raw_s),
      .q   (dly_s)
   );

   assign hcount_out      = hcount_r;
   assign vcount_out      = vcount_r;
   assign new_frame_out   = new_frame_r;
   assign active_draw_out = dly_s.active;
   assign hor_sync_out    = dly_s.hsync;
   assign vert_sync_out   = dly_s.vsync;

`ifdef VIDEO_FRAME_COUNT_EN
   localparam frame_t FPS_LAST_C = frame_t'(FPS - 1);
   frame_t frame_count_r;

   // Frame index steps once per frame pulse and wraps at FPS.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         frame_count_r <= 6'd0;
      end else if (new_frame_r) begin
         if (frame_count_r == FPS_LAST_C) begin
            frame_count_r <= 6'd0;
         end else begin
            frame_count_r <= frame_count_r + 6'd1;
         end
      end else begin
         frame_count_r <= frame_count_r;
      end
   end

   assign frame_count_out = frame_count_r;
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench: three instances (small raster PIPE_DEPTH 4 and 1, full 720p PIPE_DEPTH 8)
// compared every cycle against an arithmetic raster model indexed by cycles since reset release.
module tb_video_timing_ctrl;

   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      int pd; int fps;
   } tp_t;

   typedef struct packed {
      int h; int v; int act; int hsy; int vsy; int nf; int fc;
   } ex_t;

   localparam tp_t PA = '{ha:20, hfp:3, hs:4, hbp:5, va:10, vfp:2, vs:2, vbp:3, pd:4, fps:3};
   localparam tp_t PB = '{ha:20, hfp:3, hs:4, hbp:5, va:10, vfp:2, vs:2, vbp:3, pd:1, fps:3};
   localparam tp_t PC = '{ha:1280, hfp:110, hs:40, hbp:220, va:720, vfp:5, vs:5, vbp:20, pd:8, fps:60};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   k;
   int   checks = 0;
   int   errors = 0;

   logic [10:0] hc_a, hc_b, hc_c;
   logic [9:0]  vc_a, vc_b, vc_c;
   logic        act_a, act_b, act_c, hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, nf_a, nf_b, nf_c;
`ifdef VIDEO_FRAME_COUNT_EN
   logic [5:0]  fc_a, fc_b, fc_c;
`endif

   always #5 clk = ~clk;

   // Cycles since reset release: the model's only notion of time.
   always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   video_timing_ctrl #(.H_ACTIVE(PA.ha), .H_FP(PA.hfp), .H_SYNC(PA.hs), .H_BP(PA.hbp),
      .V_ACTIVE(PA.va), .V_FP(PA.vfp), .V_SYNC(PA.vs), .V_BP(PA.vbp), .PIPE_DEPTH(PA.pd), .FPS(PA.fps))
   dut_a (.clk_in(clk), .rst_in(rst), .hcount_out(hc_a), .vcount_out(vc_a), .active_draw_out(act_a),
      .hor_sync_out(hs_a), .vert_sync_out(vs_a), .new_frame_out(nf_a)
`ifdef VIDEO_FRAME_COUNT_EN
      , .frame_count_out(fc_a)
`endif
   );

   video_timing_ctrl #(.H_ACTIVE(PB.ha), .H_FP(PB.hfp), .H_SYNC(PB.hs), .H_BP(PB.hbp),
      .V_ACTIVE(PB.va), .V_FP(PB.vfp), .V_SYNC(PB.vs), .V_BP(PB.vbp), .PIPE_DEPTH(PB.pd), .FPS(PB.fps))
   dut_b (.clk_in(clk), .rst_in(rst), .hcount_out(hc_b), .vcount_out(vc_b), .active_draw_out(act_b),
      .hor_sync_out(hs_b), .vert_sync_out(vs_b), .new_frame_out(nf_b)
`ifdef VIDEO_FRAME_COUNT_EN
      , .frame_count_out(fc_b)
`endif
   );

   video_timing_ctrl #(.PIPE_DEPTH(PC.pd))
   dut_c (.clk_in(clk), .rst_in(rst), .hcount_out(hc_c), .vcount_out(vc_c), .active_draw_out(act_c),
      .hor_sync_out(hs_c), .vert_sync_out(vs_c), .new_frame_out(nf_c)
`ifdef VIDEO_FRAME_COUNT_EN
      , .frame_count_out(fc_c)
`endif
   );

   // Expected outputs k cycles after release, straight from the raster rules.
   function automatic ex_t model(input int kk, input tp_t p);
      ex_t e;
      int  ht, vt, j, hh, vv, ft, pnf;
      ht = p.ha + p.hfp + p.hs + p.hbp;
      vt = p.va + p.vfp + p.vs + p.vbp;
      e = '0;
      e.h  = kk % ht;
      e.v  = (kk / ht) % vt;
      e.nf = int'(e.h == p.ha && e.v == p.va);
      if (kk >= p.pd) begin
         j  = kk - p.pd;
         hh = j % ht;
         vv = (j / ht) % vt;
         e.act = int'(hh < p.ha && vv < p.va);
         e.hsy = int'(hh >= p.ha + p.hfp && hh < p.ha + p.hfp + p.hs);
         e.vsy = int'(vv >= p.va + p.vfp && vv < p.va + p.vfp + p.vs);
      end
      ft  = ht * vt;
      pnf = p.va * ht + p.ha;
      e.fc = (kk > pnf) ? (((kk - pnf - 1) / ft + 1) % p.fps) : 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d k=%0d t=%0t", name, act, req, k, $time);
      end
   endtask

   task automatic chk_dut(input string tag, input tp_t p, input logic [10:0] h, input logic [9:0] v,
                          input logic a, input logic hs, input logic vs, input logic nf);
      ex_t e;
      e = rst ? ex_t'('0) : model(k, p);
      chk({tag, "_hcount"}, 32'(h), e.h);
      chk({tag, "_vcount"}, 32'(v), e.v);
      chk({tag, "_active"}, 32'(a), e.act);
      chk({tag, "_hsync"}, 32'(hs), e.hsy);
      chk({tag, "_vsync"}, 32'(vs), e.vsy);
      chk({tag, "_new_frame"}, 32'(nf), e.nf);
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_a_zero"}, {hc_a, vc_a, act_a, hs_a, vs_a, nf_a}, 32'd0);
      chk({tag, "_b_zero"}, {hc_b, vc_b, act_b, hs_b, vs_b, nf_b}, 32'd0);
      chk({tag, "_c_zero"}, {hc_c, vc_c, act_c, hs_c, vs_c, nf_c}, 32'd0);
`ifdef VIDEO_FRAME_COUNT_EN
      chk({tag, "_fc_zero"}, {fc_a, fc_b, fc_c}, 32'd0);
`endif
   endtask

   // Per-cycle comparison on the falling edge, away from the active edge.
   always @(negedge clk) begin
      chk_dut("a", PA, hc_a, vc_a, act_a, hs_a, vs_a, nf_a);
      chk_dut("b", PB, hc_b, vc_b, act_b, hs_b, vs_b, nf_b);
      chk_dut("c", PC, hc_c, vc_c, act_c, hs_c, vs_c, nf_c);
`ifdef VIDEO_FRAME_COUNT_EN
      chk("a_frame_count", 32'(fc_a), rst ? 0 : model(k, PA).fc);
      chk("b_frame_count", 32'(fc_b), rst ? 0 : model(k, PB).fc);
      chk("c_frame_count", 32'(fc_c), rst ? 0 : model(k, PC).fc);
`endif
      if (!rst && k == 1650) begin
         chk("c_line_wrap_h", 32'(hc_c), 32'd0);
         chk("c_line_wrap_v", 32'(vc_c), 32'd1);
      end
      if (!rst && k == 3) chk("a_active_before_pipe", 32'(act_a), 32'd0);
      if (!rst && k == 4) chk("a_active_first_rise", 32'(act_a), 32'd1);
   end

   initial begin
      int ex_h, ex_v;
      // Pin the model itself with hand-computed values.
      ex_h = model(1650, PC).h;
      ex_v = model(1650, PC).v;
      chk("pin_c_wrap_h", ex_h, 32'd0);
      chk("pin_c_wrap_v", ex_v, 32'd1);
      chk("pin_c_hsync_rise", model(1398, PC).hsy, 32'd1);
      chk("pin_c_hsync_pre", model(1397, PC).hsy, 32'd0);
      chk("pin_c_hsync_last", model(1437, PC).hsy, 32'd1);
      chk("pin_c_hsync_end", model(1438, PC).hsy, 32'd0);
      chk("pin_a_new_frame", model(340, PA).nf, 32'd1);
      chk("pin_a_vsync", model(412, PA).vsy, 32'd1);

      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      repeat (3400) @(posedge clk);
      #2 rst = 1'b1;
      #1 zero_chk("async_rst_1");
      @(posedge clk);
      #3 rst = 1'b0;

      // Assert reset while instance a is inside both sync pulses.
      repeat (412) @(posedge clk);
      #1;
      chk("a_mid_hsync", 32'(hs_a), 32'd1);
      chk("a_mid_vsync", 32'(vs_a), 32'd1);
      #1 rst = 1'b1;
      #1 zero_chk("async_rst_mid_sync");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(40, 900)) @(posedge clk);
         #($urandom_range(1, 4)) rst = 1'b1;
         #0.5 zero_chk("async_rst_rand");
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #3 rst = 1'b0;
      end
      repeat (600) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
